// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a self-clearing sequencer.
// The ready flag is low while the sequencer walks every entry to zero.
module regfile_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  input  logic [ADDR_W-1:0] A3,
  input  logic              WE3,
  input  logic [DATA_W-1:0] WD3,
  input  logic              clr,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic              ready
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, ready_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;
  logic              user_wr_c;
  logic              bypass_live_c;

  // A host write that would actually land: not to a hardwired zero entry.
  assign user_wr_c = WE3 && !((ZERO_REG != 0) && (A3 == '0));

  // Bypass applies only when the host write is accepted this cycle.
  assign bypass_live_c = (BYPASS != 0) && ready_q && !clr && user_wr_c;

  // State, counter and ready registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Next-state logic and selection of the single storage write per cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ready_d   = ready_q;
    wr_en_c   = 1'b0;
    wr_addr_c = A3;
    wr_data_c = WD3;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (clr) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
            ready_d = 1'b0;
          end else if (user_wr_c) begin
            wr_en_c = 1'b1;
          end
        end
        S_CLEAR: begin
          wr_en_c   = 1'b1;
          wr_addr_c = cnt_q;
          wr_data_c = '0;
          cnt_d     = cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end
        end
        default: begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // Storage array; contents are meaningless until the first clear completes.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wr_addr_c] <= wr_data_c;
    end
  end

  // Combinational read ports.
  always_comb begin
    RD1 = mem[A1];
    if (!ready_q) begin
      RD1 = '0;
    end else if ((ZERO_REG != 0) && (A1 == '0)) begin
      RD1 = '0;
    end else if (bypass_live_c && (A3 == A1)) begin
      RD1 = WD3;
    end
  end

  always_comb begin
    RD2 = mem[A2];
    if (!ready_q) begin
      RD2 = '0;
    end else if ((ZERO_REG != 0) && (A2 == '0)) begin
      RD2 = '0;
    end else if (bypass_live_c && (A3 == A2)) begin
      RD2 = WD3;
    end
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: three configurations driven in lockstep and checked
// every cycle against an array-based reference model, plus literal spot checks.
module tb_regfile_param;

  localparam int N = 3;
  // 0: 32x32 zero+bypass, 1: 32x32 plain, 2: 8x16 zero+bypass
  localparam int DEP   [N] = '{32, 32, 8};
  localparam bit ZR    [N] = '{1'b1, 1'b0, 1'b1};
  localparam bit BP    [N] = '{1'b1, 1'b0, 1'b1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v [N];
  logic        clr_v [N];
  logic        we_v  [N];
  logic [4:0]  a1_v  [N];
  logic [4:0]  a2_v  [N];
  logic [4:0]  a3_v  [N];
  logic [31:0] wd_v  [N];

  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
  logic [15:0] rd1_2, rd2_2;
  logic        rdy0, rdy1, rdy2;
  logic [31:0] rd1_v [N];
  logic [31:0] rd2_v [N];
  logic        rdy_v [N];

  always_comb begin
    rd1_v[0] = rd1_0; rd2_v[0] = rd2_0; rdy_v[0] = rdy0;
    rd1_v[1] = rd1_1; rd2_v[1] = rd2_1; rdy_v[1] = rdy1;
    rd1_v[2] = {16'h0, rd1_2}; rd2_v[2] = {16'h0, rd2_2}; rdy_v[2] = rdy2;
  end

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut0 (
    .clk(clk), .rst(rst_v[0]), .A1(a1_v[0]), .A2(a2_v[0]), .A3(a3_v[0]),
    .WE3(we_v[0]), .WD3(wd_v[0]), .clr(clr_v[0]),
    .RD1(rd1_0), .RD2(rd2_0), .ready(rdy0));

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst_v[1]), .A1(a1_v[1]), .A2(a2_v[1]), .A3(a3_v[1]),
    .WE3(we_v[1]), .WD3(wd_v[1]), .clr(clr_v[1]),
    .RD1(rd1_1), .RD2(rd2_1), .ready(rdy1));

  regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut2 (
    .clk(clk), .rst(rst_v[2]), .A1(a1_v[2][2:0]), .A2(a2_v[2][2:0]), .A3(a3_v[2][2:0]),
    .WE3(we_v[2]), .WD3(wd_v[2][15:0]), .clr(clr_v[2]),
    .RD1(rd1_2), .RD2(rd2_2), .ready(rdy2));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: contents plus number of clear edges still owed.
  logic [31:0] mem [N][32];
  int          left [N];
  bit          started [N];

  initial begin
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      started[i] = 1'b0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (rst_v[i]) begin
        left[i] = DEP[i];
        started[i] = 1'b1;
      end else if (left[i] > 0) begin
        mem[i][DEP[i] - left[i]] = 32'h0;
        left[i] = left[i] - 1;
      end else if (clr_v[i]) begin
        left[i] = DEP[i];
      end else if (we_v[i] && !(ZR[i] && a3_v[i] == 5'd0)) begin
        mem[i][a3_v[i]] = wd_v[i];
      end
    end
  end

  function automatic logic [31:0] exp_rd(int i, logic [4:0] a);
    if (left[i] > 0) return 32'h0;
    if (ZR[i] && a == 5'd0) return 32'h0;
    if (BP[i] && we_v[i] && !clr_v[i] && a3_v[i] == a && !(ZR[i] && a3_v[i] == 5'd0))
      return wd_v[i];
    return mem[i][a];
  endfunction

  task automatic check32(string name, int i, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d @%0t: got %h want %h", name, i, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (started[i]) begin
        check32("ready", i, {31'h0, rdy_v[i]}, {31'h0, left[i] == 0});
        check32("rd1", i, rd1_v[i], exp_rd(i, a1_v[i]));
        check32("rd2", i, rd2_v[i], exp_rd(i, a2_v[i]));
      end
    end
  end

  task automatic drive(logic r, logic c, logic w, logic [4:0] a1, logic [4:0] a2,
                       logic [4:0] a3, logic [31:0] wd);
    for (int i = 0; i < N; i++) begin
      rst_v[i] = r;
      clr_v[i] = c;
      we_v[i]  = w;
      a1_v[i]  = (i == 2) ? (a1 & 5'd7) : a1;
      a2_v[i]  = (i == 2) ? (a2 & 5'd7) : a2;
      a3_v[i]  = (i == 2) ? (a3 & 5'd7) : a3;
      wd_v[i]  = (i == 2) ? (wd & 32'h0000_FFFF) : wd;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Edges from now until ready rises, for the 32-deep and 8-deep instances.
  task automatic measure(output int k0, output int k2);
    k0 = -1;
    k2 = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (k2 < 0 && rdy2) k2 = k;
      if (rdy0) begin
        k0 = k;
        break;
      end
    end
  endtask

  int k0, k2;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    tick();
    check32("ready_in_rst", 0, {31'h0, rdy0}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0, 32'h0);
    measure(k0, k2);
    check32("clear_len32", 0, k0, 32);
    check32("clear_len8", 2, k2, 8);
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 1'b0, 5'(a), 5'(31 - a), 5'd0, 32'h0);
      @(negedge clk);
      tick();
    end

    // Write/read and zero register
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'h12345678);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    check32("lit_rd5", 0, rd1_0, 32'hDEADBEEF);
    check32("lit_zero", 0, rd2_0, 32'h0);
    check32("lit_r0_plain", 1, rd2_1, 32'h12345678);
    check32("lit_rd5_16", 2, {16'h0, rd1_2}, 32'h0000BEEF);
    tick();

    // Bypass
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11);
    tick();
    drive(1'b0, 1'b0, 1'b1, 5'd7, 5'd0, 5'd7, 32'h22);
    @(negedge clk);
    check32("lit_bypass_on", 0, rd1_0, 32'h22);
    check32("lit_bypass_off", 1, rd1_1, 32'h11);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    check32("lit_after_on", 0, rd1_0, 32'h22);
    check32("lit_after_off", 1, rd1_1, 32'h22);
    tick();

    // clr with a same-cycle write drops the write
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd4, 32'h99);
    tick();
    drive(1'b0, 1'b1, 1'b1, 5'd4, 5'd0, 5'd4, 32'h55);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd4, 5'd3, 5'd0, 32'h0);
    measure(k0, k2);
    check32("clr_len32", 0, k0, 32);
    @(negedge clk);
    check32("lit_e4_cleared", 0, rd1_0, 32'h0);
    tick();

    // Mid-clear reset, writes and clr pulses while clearing
    drive(1'b0, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
    tick();
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, (k == 3 || k == 6), 1'b1, 5'd3, 5'd4, 5'd3, 32'hAA);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 32'h0);
    measure(k0, k2);
    check32("midrst_len32", 0, k0, 32);
    check32("midrst_len8", 2, k2, 8);
    @(negedge clk);
    check32("lit_e3_blocked", 0, rd1_0, 32'h0);
    check32("lit_e4_zero", 0, rd2_0, 32'h0);
    tick();

    // Narrow instance full-scale value
    drive(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h0000FFFF);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0);
    @(negedge clk);
    check32("lit_ffff", 2, {16'h0, rd1_2}, 32'h0000FFFF);
    tick();

    // Randomised traffic
    for (int k = 0; k < 1000; k++) begin
      logic [4:0] a1, a2, a3;
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
            ($urandom_range(0, 1) == 1), a1, a2, a3, $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
